updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down modulo counter with a run-time bound, a run-time step, a synchronous load and a selectable wrap or saturate mode. It is the general-purpose successor to the fixed-step, up-only modulo counter. Timers, address generators and rate dividers instantiate it directly. All outputs are registered and there is one clock domain.

## Interface
- `WIDTH`, default 16: counter, bound, step and load width in bits.
- `RESET_VAL`, default 0: value `cnt` takes on reset; must be less than every bound used.
- `clk`, input, 1: rising-edge clock.
- `reset_n`, input, 1: asynchronous, active-low reset. Assertion is immediate; deassertion is synchronised externally.
- `en`, input, 1: advance the count by `step` this cycle.
- `dir`, input, 1: 1 counts up, 0 counts down.
- `mode`, input, 1: `MODE_WRAP` (0) or `MODE_SAT` (1).
- `bound`, input, WIDTH: count range is 0..`bound`-1; `bound`=0 means the full range 0..2^WIDTH-1.
- `step`, input, WIDTH: increment magnitude.
- `load`, input, 1: synchronous load of `load_val`.
- `load_val`, input, WIDTH: value to load.
- `cnt`, output, WIDTH: current count.
- `tc`, output, 1: one-cycle pulse; the last update wrapped or hit a limit.
- `at_max`, output, 1: `cnt` equals `bound`-1.
- `at_min`, output, 1: `cnt` equals 0.
- `err`, output, 1: sticky flag for an illegal step; cleared only by reset.

## Operation
- Define the effective bound as B = (`bound`==0) ? 2^WIDTH : `bound`. All arithmetic is done at WIDTH+1 bits, so no intermediate result overflows.
- Priority order: reset, then `load`, then `en`, then hold.
- **Load:** `cnt` <= min(`load_val`, B-1). `tc` stays 0.
- **Enable with `step` = 0:** hold; `tc` stays 0.
- **Enable with `step` >= B:** illegal. `cnt` holds, `err` <= 1, `tc` stays 0.
- **Out-of-range count:** if `cnt` >= B on an enabled cycle (for example, after `bound` was lowered), `cnt` goes to 0 when counting up or B-1 when counting down. `tc` <= 1.
- **Up, wrap mode:** s = `cnt`+`step`. If s >= B, `cnt` <= s-B and `tc` <= 1. Otherwise `cnt` <= s.
- **Up, saturate mode:** if s >= B, `cnt` <= B-1 and `tc` <= 1. Otherwise `cnt` <= s.
- **Down, wrap mode:** if `cnt` < `step`, `cnt` <= `cnt`+B-`step` and `tc` <= 1. Otherwise `cnt` <= `cnt`-`step`.
- **Down, saturate mode:** if `cnt` < `step`, `cnt` <= 0 and `tc` <= 1. Otherwise `cnt` <= `cnt`-`step`.
- **Already at the limit in saturate mode:** enabling at the limit (`cnt`=B-1 counting up, or 0 counting down) still pulses `tc` each enabled cycle, and `cnt` holds.
- **Flags:** `at_max` and `at_min` are registered from the next value, so they are coherent with `cnt`. When B=1, both are 1.
- **Control changes:** `mode`, `dir`, `bound` and `step` may change on any cycle. They take effect on the update in the same cycle.

## Timing
- **Reset values:** `cnt`=`RESET_VAL`, `tc`=0, `err`=0. `at_max` and `at_min` are derived from `RESET_VAL` and the `bound` value in effect at reset.
- **Latency:** one cycle from the sampled `en` or `load` edge to the new `cnt` and flags.
- **`tc` pulse:** high for exactly the cycle in which the wrapped or limited `cnt` is first visible.
- **Reset mid-count:** outputs go to their reset values asynchronously. The first update after `reset_n` rises follows the normal rules.
- **Simultaneous `load` and `en`:** the load wins; `step` is ignored and `tc` stays 0.

## Structure
- `counter_pkg` holds the `MODE_WRAP`/`MODE_SAT` localparams and an effective-bound helper function. Future counter blocks import the same package.
- `counter_next` is a combinational sub-module. It takes `cnt`, B, `step`, `dir` and `mode`, and returns the next count, the wrap/limit indication and the illegal-step indication.
- `updown_mod_counter` contains the register stage, the load/enable priority, the `err` sticky flag and the `at_max`/`at_min` registers.

## Test plan
- **Wrap up:** WIDTH=8, `bound`=10, `step`=3, up, wrap, reset to 0, `en` held -> `cnt` 3,6,9,2,5. `tc` is high only in the cycle `cnt`=2.
- **Saturate down:** `bound`=10, `step`=4, down, saturate, load 6 then enable -> `cnt` 6,2,0,0. `tc` is high in the cycles `cnt` goes to 0 and holds at 0. `at_min` is high from the first 0.
- **Illegal step and clamped load:** `bound`=5, `step`=5, enable -> `cnt` holds and `err` goes to 1 and stays. A load of 9 with `bound`=5 -> `cnt`=4 and `at_max`=1.
- **Full range:** `bound`=0, WIDTH=8, `step`=1, `cnt`=255, up, wrap -> `cnt`=0 and `tc`=1. The same case with `step`=0 -> hold and `tc`=0.
- **Bound lowered below count:** `cnt`=8, `bound` changed to 6 with `en` high, down -> `cnt`=5 and `tc`=1. The same case counting up -> `cnt`=0.
- **Reset and load priority:** `reset_n` pulled low mid-cycle -> `cnt`=`RESET_VAL` with no clock edge. `load` and `en` asserted together -> `load_val` is taken and `tc`=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for counter blocks: mode encodings and effective-bound helper.
// Latency: none (definitions only).
// Backpressure: not applicable.
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widest counter the helper supports; callers narrow the result with a cast.
    localparam int unsigned MAX_WIDTH = 64;

    // Effective bound B: a programmed bound of zero selects the full 2^width range.
    // The result is one bit wider than the counter so 2^width is representable.
    function automatic logic [MAX_WIDTH:0] eff_bound(input logic [MAX_WIDTH-1:0] bound,
                                                     input int unsigned        width);
        if (bound == '0) begin
            return (MAX_WIDTH+1)'(1) << width;
        end
        return {1'b0, bound};
    endfunction

endpackage

// File: rtl/counter_next.sv
// Next-count logic for the up/down modulo counter (wrap or saturate).
// Latency: purely combinational.
// Backpressure: none; result is consumed by the register stage in the parent.
//
// Ports:
//   cnt_i     current count
//   bnd_i     effective bound B (WIDTH+1 bits, 1..2^WIDTH)
//   step_i    step magnitude
//   dir_i     1 = up, 0 = down
//   mode_i    MODE_WRAP / MODE_SAT
//   nxt_o     next count
//   tc_o      update wrapped, saturated or recovered from an out-of-range count
//   illegal_o step >= B (count must hold)
module counter_next
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] cnt_i,
    input  logic [WIDTH:0]   bnd_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic             dir_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] nxt_o,
    output logic             tc_o,
    output logic             illegal_o
);

    // Everything is evaluated at WIDTH+1 bits. Because cnt < B and step < B on
    // the arithmetic paths, cnt+step and cnt+B-step are both below 2B <= 2^(WIDTH+1).
    logic [WIDTH:0] cnt_w;
    logic [WIDTH:0] step_w;
    logic [WIDTH:0] sum_w;
    logic [WIDTH:0] res_w;

    assign cnt_w  = {1'b0, cnt_i};
    assign step_w = {1'b0, step_i};
    assign sum_w  = cnt_w + step_w;

    always_comb begin
        res_w     = cnt_w;
        tc_o      = 1'b0;
        illegal_o = 1'b0;
        if (step_w != '0) begin
            if (step_w >= bnd_i) begin
                illegal_o = 1'b1;
            end else if (cnt_w >= bnd_i) begin
                // Bound was lowered under the count: snap into range.
                res_w = dir_i ? '0 : (bnd_i - 1'b1);
                tc_o  = 1'b1;
            end else if (dir_i) begin
                if (sum_w >= bnd_i) begin
                    res_w = (mode_i == MODE_WRAP) ? (sum_w - bnd_i) : (bnd_i - 1'b1);
                    tc_o  = 1'b1;
                end else begin
                    res_w = sum_w;
                end
            end else begin
                if (cnt_w < step_w) begin
                    res_w = (mode_i == MODE_WRAP) ? (cnt_w + bnd_i - step_w) : '0;
                    tc_o  = 1'b1;
                end else begin
                    res_w = cnt_w - step_w;
                end
            end
        end
        // All results are below B <= 2^WIDTH, so the top bit is always zero.
        nxt_o = WIDTH'(res_w);
    end

endmodule

// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with run-time bound/step, synchronous load, wrap or saturate.
// Latency: one cycle from sampled en/load to cnt and flags; all outputs registered.
// Backpressure: none; en is sampled every cycle, load takes priority over en.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   en, dir, mode         advance enable, direction (1 = up), MODE_WRAP/MODE_SAT
//   bound, step           range 0..bound-1 (0 = full range), step magnitude
//   load, load_val        synchronous load, clamped to bound-1
//   cnt, tc               count and one-cycle wrap/limit pulse
//   at_max, at_min        cnt == B-1, cnt == 0
//   err                   sticky illegal-step flag, cleared only by reset
module updown_mod_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             dir,
    input  logic             mode,
    input  logic [WIDTH-1:0] bound,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             at_max,
    output logic             at_min,
    output logic             err
);

    logic [WIDTH:0]   bnd_eff;
    logic [WIDTH:0]   bnd_max;
    logic [WIDTH-1:0] nxt_cnt;
    logic             nxt_tc;
    logic             nxt_illegal;

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             err_q, err_d;
    logic             at_max_q, at_max_d;
    logic             at_min_q, at_min_d;
    logic             rst_at_max;

    assign bnd_eff = (WIDTH+1)'(eff_bound(MAX_WIDTH'(bound), WIDTH));
    assign bnd_max = bnd_eff - 1'b1;

    counter_next #(
        .WIDTH (WIDTH)
    ) u_next (
        .cnt_i     (cnt_q),
        .bnd_i     (bnd_eff),
        .step_i    (step),
        .dir_i     (dir),
        .mode_i    (mode),
        .nxt_o     (nxt_cnt),
        .tc_o      (nxt_tc),
        .illegal_o (nxt_illegal)
    );

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        err_d = err_q;
        if (load) begin
            cnt_d = ({1'b0, load_val} > bnd_max) ? WIDTH'(bnd_max) : load_val;
        end else if (en) begin
            cnt_d = nxt_cnt;
            tc_d  = nxt_tc;
            err_d = err_q | nxt_illegal;
        end
    end

    // Flags come from the next value so they land in the same cycle as cnt.
    assign at_max_d   = ({1'b0, cnt_d} == bnd_max);
    assign at_min_d   = (cnt_d == '0);
    // While in reset, at_max tracks the bound currently presented.
    assign rst_at_max = ({1'b0, RESET_VAL} == bnd_max);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= RESET_VAL;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
            at_max_q <= rst_at_max;
            at_min_q <= (RESET_VAL == '0);
        end else begin
            cnt_q    <= cnt_d;
            tc_q     <= tc_d;
            err_q    <= err_d;
            at_max_q <= at_max_d;
            at_min_q <= at_min_d;
        end
    end

    assign cnt    = cnt_q;
    assign tc     = tc_q;
    assign err    = err_q;
    assign at_max = at_max_q;
    assign at_min = at_min_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Self-checking bench for updown_mod_counter (WIDTH=8, RESET_VAL=0).
// Latency: expects new outputs one cycle after each driven vector.
// Backpressure: not applicable; expected results queue until the DUT edge.
module tb_updown_mod_counter;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset_n;
    logic         en;
    logic         dir;
    logic         mode;
    logic [W-1:0] bound;
    logic [W-1:0] step;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] cnt;
    logic         tc;
    logic         at_max;
    logic         at_min;
    logic         err;

    updown_mod_counter #(
        .WIDTH     (W),
        .RESET_VAL (8'd0)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .dir      (dir),
        .mode     (mode),
        .bound    (bound),
        .step     (step),
        .load     (load),
        .load_val (load_val),
        .cnt      (cnt),
        .tc       (tc),
        .at_max   (at_max),
        .at_min   (at_min),
        .err      (err)
    );

    typedef struct packed {
        logic         ld;
        logic         en;
        logic         dir;
        logic         mode;
        logic [W-1:0] bound;
        logic [W-1:0] step;
        logic [W-1:0] lv;
        logic [W-1:0] cnt;
        logic         tc;
        logic         mx;
        logic         mn;
        logic         er;
    } vec_t;

    // Expected output word: {cnt, tc, at_max, at_min, err}
    logic [W+3:0] exp_q[$];
    int           n_applied;
    int           n_miss;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic vec_t mk(input logic ld, input logic e, input logic d, input logic m,
                                input int b, input int s, input int lv,
                                input int c, input logic t, input logic mx, input logic mn,
                                input logic er);
        vec_t v;
        v.ld = ld; v.en = e; v.dir = d; v.mode = m;
        v.bound = W'(b); v.step = W'(s); v.lv = W'(lv);
        v.cnt = W'(c); v.tc = t; v.mx = mx; v.mn = mn; v.er = er;
        return v;
    endfunction

    function automatic logic [W+3:0] pack_exp(input int c, input logic t, input logic mx,
                                               input logic mn, input logic er);
        return {W'(c), t, mx, mn, er};
    endfunction

    task automatic check(input string name);
        logic [W+3:0] act;
        logic [W+3:0] expv;
        act = {cnt, tc, at_max, at_min, err};
        n_applied++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL %s: no expected entry queued, got cnt=%0d tc=%0b max=%0b min=%0b err=%0b",
                     name, cnt, tc, at_max, at_min, err);
        end else begin
            expv = exp_q.pop_front();
            if (act !== expv) begin
                n_miss++;
                $display("FAIL %s: got cnt=%0d tc=%0b max=%0b min=%0b err=%0b, want cnt=%0d tc=%0b max=%0b min=%0b err=%0b",
                         name, cnt, tc, at_max, at_min, err,
                         expv[W+3:4], expv[3], expv[2], expv[1], expv[0]);
            end
        end
    endtask

    task automatic apply(input vec_t v, input string name);
        @(negedge clk);
        load     = v.ld;
        en       = v.en;
        dir      = v.dir;
        mode     = v.mode;
        bound    = v.bound;
        step     = v.step;
        load_val = v.lv;
        exp_q.push_back({v.cnt, v.tc, v.mx, v.mn, v.er});
        @(posedge clk);
        #1;
        check(name);
    endtask

    vec_t vecs[30];

    initial begin
        n_applied = 0;
        n_miss    = 0;

        //                 ld en dir md bnd stp lv   cnt tc mx mn er
        vecs[0]  = mk(0, 1, 1, 0, 10, 3, 0,    3, 0, 0, 0, 0); // wrap up
        vecs[1]  = mk(0, 1, 1, 0, 10, 3, 0,    6, 0, 0, 0, 0);
        vecs[2]  = mk(0, 1, 1, 0, 10, 3, 0,    9, 0, 1, 0, 0);
        vecs[3]  = mk(0, 1, 1, 0, 10, 3, 0,    2, 1, 0, 0, 0);
        vecs[4]  = mk(0, 1, 1, 0, 10, 3, 0,    5, 0, 0, 0, 0);
        vecs[5]  = mk(1, 0, 0, 1, 10, 4, 6,    6, 0, 0, 0, 0); // saturate down
        vecs[6]  = mk(0, 1, 0, 1, 10, 4, 0,    2, 0, 0, 0, 0);
        vecs[7]  = mk(0, 1, 0, 1, 10, 4, 0,    0, 1, 0, 1, 0);
        vecs[8]  = mk(0, 1, 0, 1, 10, 4, 0,    0, 1, 0, 1, 0);
        vecs[9]  = mk(1, 0, 1, 0, 0,  1, 255,  255, 0, 1, 0, 0); // full range
        vecs[10] = mk(0, 1, 1, 0, 0,  1, 0,    0, 1, 0, 1, 0);
        vecs[11] = mk(1, 0, 1, 0, 0,  0, 255,  255, 0, 1, 0, 0);
        vecs[12] = mk(0, 1, 1, 0, 0,  0, 0,    255, 0, 1, 0, 0);
        vecs[13] = mk(1, 0, 0, 0, 10, 1, 8,    8, 0, 0, 0, 0); // bound lowered
        vecs[14] = mk(0, 1, 0, 0, 6,  1, 0,    5, 1, 1, 0, 0);
        vecs[15] = mk(1, 0, 1, 0, 10, 1, 8,    8, 0, 0, 0, 0);
        vecs[16] = mk(0, 1, 1, 0, 6,  1, 0,    0, 1, 0, 1, 0);
        vecs[17] = mk(1, 1, 1, 0, 10, 3, 7,    7, 0, 0, 0, 0); // load beats en
        vecs[18] = mk(0, 1, 1, 1, 10, 3, 0,    9, 1, 1, 0, 0); // saturate up
        vecs[19] = mk(0, 1, 1, 1, 10, 3, 0,    9, 1, 1, 0, 0);
        vecs[20] = mk(0, 1, 0, 0, 10, 4, 0,    5, 0, 0, 0, 0); // wrap down
        vecs[21] = mk(0, 1, 0, 0, 10, 4, 0,    1, 0, 0, 0, 0);
        vecs[22] = mk(0, 1, 0, 0, 10, 4, 0,    7, 1, 0, 0, 0);
        vecs[23] = mk(0, 0, 0, 0, 10, 4, 0,    7, 0, 0, 0, 0); // idle hold
        vecs[24] = mk(0, 1, 1, 0, 5,  5, 0,    7, 0, 0, 0, 1); // illegal step
        vecs[25] = mk(0, 1, 1, 0, 5,  1, 0,    0, 1, 0, 1, 1);
        vecs[26] = mk(1, 0, 1, 0, 5,  1, 9,    4, 0, 1, 0, 1); // clamped load
        vecs[27] = mk(1, 0, 1, 0, 1,  1, 0,    0, 0, 1, 1, 1); // B = 1
        vecs[28] = mk(0, 1, 1, 0, 1,  0, 0,    0, 0, 1, 1, 1);
        vecs[29] = mk(0, 1, 1, 0, 1,  1, 0,    0, 0, 1, 1, 1);

        // Reset state with bound = 10.
        reset_n  = 1'b1;
        en       = 1'b0;
        dir      = 1'b1;
        mode     = 1'b0;
        bound    = 8'd10;
        step     = 8'd0;
        load     = 1'b0;
        load_val = 8'd0;
        #2;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(pack_exp(0, 1'b0, 1'b0, 1'b1, 1'b0));
        check("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 30; i++) begin
            apply(vecs[i], $sformatf("vec%0d", i));
        end

        // Asynchronous reset mid-count with bound = 1: both flags set, err cleared.
        apply(mk(1, 0, 1, 0, 10, 3, 5, 5, 0, 0, 0, 1), "pre_reset_load");
        #2;
        load  = 1'b0;
        bound = 8'd1;
        #1;
        reset_n = 1'b0;
        #1;
        exp_q.push_back(pack_exp(0, 1'b0, 1'b1, 1'b1, 1'b0));
        check("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        apply(mk(0, 1, 1, 0, 10, 3, 0, 3, 0, 0, 0, 0), "post_reset_step");
        apply(mk(0, 1, 1, 0, 10, 3, 0, 6, 0, 0, 0, 0), "post_reset_step2");
        apply(mk(0, 1, 1, 0, 10, 3, 0, 9, 0, 1, 0, 0), "post_reset_step3");
        apply(mk(0, 1, 1, 0, 10, 3, 0, 2, 1, 0, 0, 0), "post_reset_wrap");
        apply(mk(0, 0, 1, 0, 10, 3, 0, 2, 0, 0, 0, 0), "tc_single_cycle");

        if (exp_q.size() != 0) begin
            n_miss++;
            $display("FAIL scoreboard_drain: %0d expected entries left, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
